// File: rtl/spike_window_counter_bank.sv
// ---------------------------------------------------------------------------
// spike_window_counter_bank
//
// Counts spike rising edges on NCH channels inside windows that end on a
// one-cycle window_tick. At each tick every count is latched into a snapshot.
// The snapshot is then streamed as (channel id, count) words, channel 0
// first, toward a pipe-out endpoint.
//
// Ports:
//   clk, reset_n         clock (rising edge) and async active-low reset
//   spike[NCH]           spike levels, bit i = channel i
//   ch_enable[NCH]       per-channel count enable (disabled channel holds)
//   mode_cumulative      0: counters restart every window, 1: free-running
//   window_tick          one-cycle end-of-window pulse
//   clear_overrun        clears the sticky overrun flag
//   count_snapshot       latched counts, channel i at [i*CW +: CW]
//   snapshot_valid       one-cycle pulse the cycle after a snapshot load
//   out_valid/out_ready  stream handshake
//   out_ch, out_count    current stream word
//   frame_done           one-cycle pulse after the last word is accepted
//   overrun              sticky: a tick arrived before the frame finished
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high. While out_valid is high and the word has not been
// accepted, out_ch/out_count hold steady unless a window_tick restarts the
// frame. out_valid never depends on out_ready.
// ---------------------------------------------------------------------------
module spike_window_counter_bank #(
    parameter int NCH = 8,
    parameter int CW  = 16,
    parameter int IDW = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH-1:0]    spike,
    input  logic [NCH-1:0]    ch_enable,
    input  logic              mode_cumulative,
    input  logic              window_tick,
    input  logic              clear_overrun,
    output logic [NCH*CW-1:0] count_snapshot,
    output logic              snapshot_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDW-1:0]    out_ch,
    output logic [CW-1:0]     out_count,
    output logic              frame_done,
    output logic              overrun
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] idx_next;
    logic           done_next;
    logic           set_overrun;
    logic           accept;
    logic           last_word;

    logic [NCH-1:0] spike_d;
    logic [NCH-1:0] inc;

    // A level held high produces a single rise.
    assign inc = spike & ~spike_d & ch_enable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spike_d        <= '0;
            snapshot_valid <= 1'b0;
        end else begin
            spike_d        <= spike;
            snapshot_valid <= window_tick;
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel counter and snapshot register
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_sat;
        logic [CW-1:0] snap;

        // Saturating increment: holds at all-ones instead of wrapping.
        assign cnt_sat = (inc[i] && (cnt != '1)) ? cnt + 1'b1 : cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt  <= '0;
                snap <= '0;
            end else if (window_tick) begin
                // Snapshot takes the count before this edge's rise; in
                // per-window mode that rise opens the next window.
                snap <= cnt;
                cnt  <= mode_cumulative ? cnt_sat : CW'(inc[i]);
            end else begin
                cnt  <= cnt_sat;
            end
        end

        assign count_snapshot[i*CW +: CW] = snap;
    end

    // -----------------------------------------------------------------------
    // Stream FSM
    // -----------------------------------------------------------------------
    assign out_valid = (state == STREAM);
    assign out_ch    = idx;
    assign accept    = out_valid & out_ready;
    assign last_word = (idx == IDW'(NCH - 1));

    always_comb begin
        out_count = '0;
        for (int i = 0; i < NCH; i++) begin
            if (idx == IDW'(i)) begin
                out_count = count_snapshot[i*CW +: CW];
            end
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        done_next   = 1'b0;
        set_overrun = 1'b0;
        case (state)
            IDLE: begin
                if (window_tick) begin
                    state_next = STREAM;
                    idx_next   = '0;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (last_word) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next   = idx + 1'b1;
                    end
                end
                // A tick restarts the frame from channel 0. It is only an
                // overrun if the old frame did not complete on this edge.
                if (window_tick) begin
                    state_next  = STREAM;
                    idx_next    = '0;
                    set_overrun = !(accept && last_word);
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            frame_done <= done_next;
            // Setting wins over a simultaneous clear.
            if (set_overrun) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_window_counter_bank.sv
module tb_spike_window_counter_bank;

    localparam int NCH  = 8;
    localparam int CW   = 4;
    localparam int IDW  = 3;
    localparam int MAXC = (1 << CW) - 1;
    localparam int W    = IDW + CW;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH-1:0]    spike = '0;
    logic [NCH-1:0]    ch_enable = '1;
    logic              mode_cumulative = 1'b0;
    logic              window_tick = 1'b0;
    logic              clear_overrun = 1'b0;
    logic [NCH*CW-1:0] count_snapshot;
    logic              snapshot_valid;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [IDW-1:0]    out_ch;
    logic [CW-1:0]     out_count;
    logic              frame_done;
    logic              overrun;

    always #5 clk = ~clk;

    spike_window_counter_bank #(.NCH(NCH), .CW(CW), .IDW(IDW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .spike           (spike),
        .ch_enable       (ch_enable),
        .mode_cumulative (mode_cumulative),
        .window_tick     (window_tick),
        .clear_overrun   (clear_overrun),
        .count_snapshot  (count_snapshot),
        .snapshot_valid  (snapshot_valid),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_ch          (out_ch),
        .out_count       (out_count),
        .frame_done      (frame_done),
        .overrun         (overrun)
    );

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    int checks = 0;
    int fails  = 0;

    int             m_cnt  [NCH];
    int             m_snap [NCH];
    logic [NCH-1:0] m_prev;
    bit             m_ov;
    logic [W-1:0]   frame_q [$];   // words of the current frame still to send
    logic [W-1:0]   exp_q   [$];   // words the model says were transferred
    logic [W-1:0]   got_q   [$];   // words seen transferring on the DUT port
    int exp_done_n = 0, got_done_n = 0;
    int exp_sv_n   = 0, got_sv_n   = 0;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i]  = 0;
            m_snap[i] = 0;
        end
        m_prev = '0;
        m_ov   = 1'b0;
        frame_q.delete();
    endfunction

    function automatic logic [NCH*CW-1:0] model_snapshot();
        logic [NCH*CW-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) r[i*CW +: CW] = CW'(m_snap[i]);
        return r;
    endfunction

    // Empties both word queues, returning the number of differing positions.
    function automatic int queue_diff(output logic [W-1:0] g0, output logic [W-1:0] e0);
        int n;
        logic [W-1:0] g, e;
        n = 0; g0 = '0; e0 = '0;
        while (got_q.size() > 0 || exp_q.size() > 0) begin
            g = 'x; e = 'x;
            if (got_q.size() > 0) g = got_q.pop_front();
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (g !== e) begin
                if (n == 0) begin g0 = g; e0 = e; end
                n++;
            end
        end
        return n;
    endfunction

    // One clock cycle: drive inputs, log the DUT port, advance the model.
    task automatic step(input logic [NCH-1:0] sp, input bit tick, input bit rdy, input bit clr);
        bit ov_set;
        int inc;
        @(negedge clk);
        spike = sp; window_tick = tick; out_ready = rdy; clear_overrun = clr;
        #1;
        if (out_valid && out_ready) got_q.push_back({out_ch, out_count});
        if (frame_done) got_done_n++;
        if (snapshot_valid) got_sv_n++;
        @(posedge clk);
        if (frame_q.size() > 0 && rdy) begin
            exp_q.push_back(frame_q.pop_front());
            if (frame_q.size() == 0) exp_done_n++;
        end
        ov_set = tick && (frame_q.size() > 0);
        if (tick) begin
            exp_sv_n++;
            frame_q.delete();
            for (int i = 0; i < NCH; i++) begin
                m_snap[i] = m_cnt[i];
                frame_q.push_back({IDW'(i), CW'(m_snap[i])});
            end
        end
        if (ov_set) m_ov = 1'b1;
        else if (clr) m_ov = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            inc = (sp[i] && !m_prev[i] && ch_enable[i]) ? 1 : 0;
            if (tick && !mode_cumulative) m_cnt[i] = inc;
            else m_cnt[i] = (m_cnt[i] + inc > MAXC) ? MAXC : m_cnt[i] + inc;
        end
        m_prev = sp;
        #1;
    endtask

    task automatic drain();
        repeat (NCH + 1) step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (count_snapshot !== '0) begin fails++; $display("FAIL reset_snapshot: got %h want 0", count_snapshot); end
        checks++; if (snapshot_valid !== 1'b0) begin fails++; $display("FAIL reset_snapshot_valid: got %b want 0", snapshot_valid); end
        checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (out_ch !== '0 || out_count !== '0) begin fails++; $display("FAIL reset_word: got ch %0d cnt %0d want 0 0", out_ch, out_count); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] g0, e0;
        int nd, ng;
        ch_enable = '1; mode_cumulative = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(NCH'(1) | ((k < 2) ? NCH'(8) : NCH'(0)), 1'b0, 1'b0, 1'b0);
            step('0, 1'b0, 1'b0, 1'b0);
        end
        step('0, 1'b1, 1'b0, 1'b0);
        checks++; if (count_snapshot !== model_snapshot()) begin fails++; $display("FAIL basic_snapshot: got %h want %h", count_snapshot, model_snapshot()); end
        checks++; if (count_snapshot[0*CW +: CW] !== CW'(5) || count_snapshot[3*CW +: CW] !== CW'(2)) begin
            fails++; $display("FAIL basic_counts: got ch0 %0d ch3 %0d want 5 2", count_snapshot[0 +: CW], count_snapshot[3*CW +: CW]);
        end
        repeat (NCH) step('0, 1'b0, 1'b1, 1'b0);
        checks++; if (frame_done !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL basic_frame_end: got done %b valid %b want 1 0", frame_done, out_valid); end
        step('0, 1'b0, 1'b0, 1'b0);
        ng = got_q.size();
        checks++; if (ng !== NCH) begin fails++; $display("FAIL basic_word_count: got %0d want %0d", ng, NCH); end
        nd = queue_diff(g0, e0);
        checks++; if (nd !== 0) begin fails++; $display("FAIL basic_stream: %0d bad words, first got %h want %h", nd, g0, e0); end
        checks++; if (got_done_n !== exp_done_n || got_sv_n !== exp_sv_n) begin
            fails++; $display("FAIL basic_pulses: got done %0d sv %0d want %0d %0d", got_done_n, got_sv_n, exp_done_n, exp_sv_n);
        end
    endtask

    task automatic test_mode0_coincident();
        logic [W-1:0] g0, e0;
        int nd;
        mode_cumulative = 1'b0;
        repeat (3) begin
            step(NCH'(2), 1'b0, 1'b0, 1'b0);
            step('0, 1'b0, 1'b0, 1'b0);
        end
        step(NCH'(2), 1'b1, 1'b0, 1'b0);
        checks++; if (count_snapshot[1*CW +: CW] !== CW'(3)) begin fails++; $display("FAIL mode0_tick_rise: got %0d want 3", count_snapshot[CW +: CW]); end
        drain();
        step('0, 1'b1, 1'b0, 1'b0);
        checks++; if (count_snapshot[1*CW +: CW] !== CW'(1)) begin fails++; $display("FAIL mode0_carry: got %0d want 1", count_snapshot[CW +: CW]); end
        checks++; if (count_snapshot !== model_snapshot()) begin fails++; $display("FAIL mode0_snapshot: got %h want %h", count_snapshot, model_snapshot()); end
        drain();
        nd = queue_diff(g0, e0);
        checks++; if (nd !== 0) begin fails++; $display("FAIL mode0_stream: %0d bad words, first got %h want %h", nd, g0, e0); end
    endtask

    task automatic test_cumulative();
        logic [W-1:0] g0, e0;
        int nd;
        mode_cumulative = 1'b0;
        step('0, 1'b1, 1'b0, 1'b0);
        drain();
        mode_cumulative = 1'b1;
        repeat (4) begin step(NCH'(1), 1'b0, 1'b0, 1'b0); step('0, 1'b0, 1'b0, 1'b0); end
        step('0, 1'b1, 1'b0, 1'b0);
        checks++; if (count_snapshot[0 +: CW] !== CW'(4)) begin fails++; $display("FAIL cumul_first: got %0d want 4", count_snapshot[0 +: CW]); end
        drain();
        repeat (2) begin step(NCH'(1), 1'b0, 1'b0, 1'b0); step('0, 1'b0, 1'b0, 1'b0); end
        step('0, 1'b1, 1'b0, 1'b0);
        checks++; if (count_snapshot[0 +: CW] !== CW'(6)) begin fails++; $display("FAIL cumul_second: got %0d want 6", count_snapshot[0 +: CW]); end
        drain();
        repeat (20) begin step(NCH'(32), 1'b0, 1'b0, 1'b0); step('0, 1'b0, 1'b0, 1'b0); end
        step('0, 1'b1, 1'b0, 1'b0);
        checks++; if (count_snapshot[5*CW +: CW] !== CW'(MAXC)) begin fails++; $display("FAIL cumul_saturate: got %0d want %0d", count_snapshot[5*CW +: CW], MAXC); end
        checks++; if (count_snapshot !== model_snapshot()) begin fails++; $display("FAIL cumul_snapshot: got %h want %h", count_snapshot, model_snapshot()); end
        drain();
        nd = queue_diff(g0, e0);
        checks++; if (nd !== 0) begin fails++; $display("FAIL cumul_stream: %0d bad words, first got %h want %h", nd, g0, e0); end
    endtask

    task automatic test_enable_hold();
        logic [NCH-1:0] sp;
        mode_cumulative = 1'b0;
        step('0, 1'b1, 1'b0, 1'b0);
        drain();
        ch_enable = ~NCH'(4);
        for (int k = 0; k < 12; k++) begin
            sp = '0;
            sp[2] = (k % 2 == 0);
            sp[4] = (k < 10);
            step(sp, 1'b0, 1'b0, 1'b0);
        end
        step('0, 1'b1, 1'b0, 1'b0);
        checks++; if (count_snapshot[2*CW +: CW] !== CW'(0) || count_snapshot[4*CW +: CW] !== CW'(1)) begin
            fails++; $display("FAIL enable_hold: got ch2 %0d ch4 %0d want 0 1", count_snapshot[2*CW +: CW], count_snapshot[4*CW +: CW]);
        end
        drain();
        ch_enable = '1;
    endtask

    task automatic test_overrun();
        logic [W-1:0] g0, e0;
        int nd;
        mode_cumulative = 1'b0;
        step('0, 1'b0, 1'b0, 1'b1);
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear0: got %b want 0", overrun); end
        repeat (6) step(NCH'($urandom), 1'b0, 1'b0, 1'b0);
        step(NCH'($urandom), 1'b1, 1'b0, 1'b0);
        repeat (3) step(NCH'($urandom), 1'b0, 1'b1, 1'b0);
        repeat (2) step(NCH'($urandom), 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_ch !== IDW'(3)) begin fails++; $display("FAIL ovr_stall: got valid %b ch %0d want 1 3", out_valid, out_ch); end
        step(NCH'($urandom), 1'b1, 1'b0, 1'b0);
        checks++; if (overrun !== 1'b1 || out_ch !== IDW'(0)) begin fails++; $display("FAIL ovr_set: got ovr %b ch %0d want 1 0", overrun, out_ch); end
        checks++; if (count_snapshot !== model_snapshot()) begin fails++; $display("FAIL ovr_snapshot: got %h want %h", count_snapshot, model_snapshot()); end
        step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b1);
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        step('0, 1'b1, 1'b0, 1'b1);
        checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
        step('0, 1'b0, 1'b0, 1'b1);
        drain();
        step('0, 1'b1, 1'b0, 1'b0);
        repeat (NCH - 1) step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b1, 1'b0);
        checks++; if (overrun !== 1'b0 || frame_done !== 1'b1 || out_valid !== 1'b1 || out_ch !== IDW'(0)) begin
            fails++; $display("FAIL ovr_coincident: got ovr %b done %b valid %b ch %0d want 0 1 1 0", overrun, frame_done, out_valid, out_ch);
        end
        drain();
        nd = queue_diff(g0, e0);
        checks++; if (nd !== 0) begin fails++; $display("FAIL ovr_stream: %0d bad words, first got %h want %h", nd, g0, e0); end
        checks++; if (got_done_n !== exp_done_n || got_sv_n !== exp_sv_n) begin
            fails++; $display("FAIL ovr_pulses: got done %0d sv %0d want %0d %0d", got_done_n, got_sv_n, exp_done_n, exp_sv_n);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [W-1:0] g0, e0;
        int nd;
        mode_cumulative = 1'b0;
        repeat (4) begin step(NCH'($urandom), 1'b0, 1'b0, 1'b0); step('0, 1'b0, 1'b0, 1'b0); end
        step('0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(NCH'($urandom), 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b0; spike = '0; out_ready = 1'b0; window_tick = 1'b0; clear_overrun = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || count_snapshot !== '0 || out_count !== '0) begin
            fails++; $display("FAIL midreset_async: got valid %b snap %h cnt %0d want 0 0 0", out_valid, count_snapshot, out_count);
        end
        model_reset();
        nd = queue_diff(g0, e0);
        checks++; if (nd !== 0) begin fails++; $display("FAIL midreset_stream: %0d bad words, first got %h want %h", nd, g0, e0); end
        @(negedge clk);
        reset_n = 1'b1;
        step('0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_idle: got %b want 0", out_valid); end
        step('0, 1'b1, 1'b0, 1'b0);
        checks++; if (count_snapshot !== '0) begin fails++; $display("FAIL midreset_counters: got %h want 0", count_snapshot); end
        drain();
        nd = queue_diff(g0, e0);
        checks++; if (nd !== 0) begin fails++; $display("FAIL midreset_frame: %0d bad words, first got %h want %h", nd, g0, e0); end
    endtask

    task automatic test_random();
        logic [W-1:0] g0, e0;
        int nd, bad_snap, bad_ov;
        bad_snap = 0; bad_ov = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 19) == 0) ch_enable = NCH'($urandom);
            if ($urandom_range(0, 49) == 0) mode_cumulative = 1'($urandom_range(0, 1));
            step(NCH'($urandom), ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0));
            if (count_snapshot !== model_snapshot()) bad_snap++;
            if (overrun !== m_ov) bad_ov++;
        end
        step('0, 1'b0, 1'b0, 1'b0);
        checks++; if (bad_snap !== 0) begin fails++; $display("FAIL rand_snapshot: got %0d bad cycles want 0", bad_snap); end
        checks++; if (bad_ov !== 0) begin fails++; $display("FAIL rand_overrun: got %0d bad cycles want 0", bad_ov); end
        nd = queue_diff(g0, e0);
        checks++; if (nd !== 0) begin fails++; $display("FAIL rand_stream: %0d bad words, first got %h want %h", nd, g0, e0); end
        checks++; if (got_done_n !== exp_done_n || got_sv_n !== exp_sv_n) begin
            fails++; $display("FAIL rand_pulses: got done %0d sv %0d want %0d %0d", got_done_n, got_sv_n, exp_done_n, exp_sv_n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mode0_coincident();
        test_cumulative();
        test_enable_hold();
        test_overrun();
        test_reset_mid_stream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/spike_window_counter_bank.md
Name: spike_window_counter_bank

Overview:
- Parametrised successor to the single-channel spike counter. It counts spike rising edges on NCH channels in parallel, within windows delimited by a one-cycle tick.
- At each window boundary it snapshots all counts. It then streams the snapshot as (channel id, count) words over a valid/ready handshake toward a pipe-out endpoint.
- It adds modes the single counter lacks: per-window clear or cumulative counting, saturation, a per-channel enable mask, and overrun detection.
- Sits between the neuron pools and the host readout/EMG/muscle blocks.

Parameters:
- NCH, 8, number of spike channels (1..64).
- CW, 16, counter and snapshot width per channel.
- IDW, 6, width of channel-id field; must satisfy 2^IDW >= NCH.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- spike, input, NCH: spike levels, synchronous to clk; bit i is channel i.
- ch_enable, input, NCH: per-channel count enable; a disabled channel holds its counter.
- mode_cumulative, input, 1: 0 = clear counters each window; 1 = free-running counters.
- window_tick, input, 1: one-cycle pulse marking end of window.
- clear_overrun, input, 1: clears the sticky overrun flag.
- count_snapshot, output, NCH*CW: latched counts; channel i occupies [i*CW +: CW].
- snapshot_valid, output, 1: one-cycle pulse when the snapshot updates.
- out_valid, output, 1: stream word valid.
- out_ready, input, 1: downstream accept.
- out_ch, output, IDW: channel id of the current word.
- out_count, output, CW: count of the current word.
- frame_done, output, 1: one-cycle pulse on acceptance of the last word (channel NCH-1).
- overrun, output, 1: sticky; a tick arrived before the previous frame finished.

Behaviour:
- Reset (reset_n=0, async): all counters, count_snapshot, spike_d history, snapshot_valid, out_valid, out_ch, out_count, frame_done and overrun go to 0. FSM goes to IDLE.
- Edge detect: spike_d <= spike every cycle. Rising edge on ch i is rise_i = spike[i] & ~spike_d[i]. A level held high counts once.
- Counter update per channel, evaluated at each edge:
  - inc_i = rise_i & ch_enable[i].
  - No tick: cnt_i <= sat(cnt_i + inc_i).
  - window_tick=1 and mode_cumulative=0: snapshot_i <= cnt_i (excludes this edge's rise), and cnt_i <= inc_i.
  - window_tick=1 and mode_cumulative=1: snapshot_i <= cnt_i, and cnt_i <= sat(cnt_i + inc_i).
- Saturation: cnt holds at 2^CW-1; no wrap. The cumulative-mode counter also saturates.
- snapshot_valid: asserted the cycle after the tick edge, for one cycle.
- FSM states: IDLE, STREAM.
  - IDLE: out_valid=0. On tick, go to STREAM with idx=0 at the same edge the snapshot loads. First out_valid is therefore visible the cycle after the tick.
  - STREAM: out_valid=1, out_ch=idx, out_count=snapshot_idx (combinational mux from the snapshot, stable while not accepted and no tick).
    - Acceptance is out_valid & out_ready. On acceptance with idx<NCH-1: idx++.
    - On acceptance with idx=NCH-1: go to IDLE and pulse frame_done next cycle.
  - Tick in STREAM without final acceptance in the same cycle: overrun <= 1, snapshot reloads, idx <= 0, stay in STREAM. Words already sent from the old frame are not retracted.
  - Tick coincident with final-word acceptance: frame_done pulses, no overrun, new frame starts at idx=0 (stay in STREAM).
- overrun: cleared only by clear_overrun or reset. If clear_overrun and a new overrun occur in the same cycle, set wins.
- Changing ch_enable or mode_cumulative mid-window takes effect on the next edge; existing counts are retained.
- Reset mid-stream: frame is abandoned, out_valid drops immediately (async).

Test Plan:
- Reset release; NCH=8; ch0 gets 5 rises, ch3 gets 2; tick -> snapshot shows ch0=5, ch3=2, others 0. Stream with out_ready=1 emits 8 words ch0..ch7 on consecutive cycles; frame_done pulses once.
- mode 0, rise on ch1 coincident with tick after 3 prior rises -> snapshot ch1=3; next window without spikes snapshots ch1=1.
- mode 1, 4 rises, tick, 2 rises, tick -> snapshots ch0 = 4 then 6. CW=4 with 20 rises -> snapshot 15 (saturated).
- ch_enable=0 on ch2 during 6 rises; spike held high for 10 cycles on ch4 -> ch2=0, ch4=1.
- out_ready=0 after 3 words; tick arrives -> overrun=1, next word is ch0 of the new snapshot. clear_overrun -> overrun=0. Tick coincident with final acceptance -> no overrun.
- Assert reset_n=0 mid-stream at word 5 -> out_valid, counts and snapshot all 0 asynchronously; FSM IDLE after release.
